// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage between the PC register and IF/ID.
//
// Issues one instruction-memory read at a time over a req/gnt + rvalid
// handshake and loads the returned word into the IF/ID register. Handles
// decode back-pressure (id_stall) and branch flush (br), and raises if_stall
// whenever a fetch is in flight so the PC can be frozen.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   pc, ce            fetch address and its valid from the PC register
//   br                branch taken: flushes the fetch and IF/ID
//   imem_req/addr     registered read request and address to memory
//   imem_gnt          memory accepts the request this cycle
//   imem_rvalid/rdata read response
//   id_stall          decode cannot accept a new instruction
//   if_stall          fetch busy; PC must hold
//   id_valid/pc/inst  IF/ID register contents
//   id_misalign       (INST_FETCH_MISALIGN_CHECK_EN only) IF/ID holds a
//                     misaligned-PC NOP instead of a real fetch
//
// Define INST_FETCH_MISALIGN_CHECK_EN to turn misaligned PCs into a NOP
// marked by id_misalign without touching memory.
module inst_fetch #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic        br,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    output logic        if_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef INST_FETCH_MISALIGN_CHECK_EN
    ,
    output logic        id_misalign
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, buf_q, buf_d, id_pc_q, id_pc_d, id_inst_q, id_inst_d;
    logic        req_q, req_d, id_valid_q, id_valid_d;
    logic        misaligned, done;
    logic [31:0] done_inst;

`ifdef INST_FETCH_MISALIGN_CHECK_EN
    logic mis_q, mis_d, id_mis_q, id_mis_d;
    assign misaligned  = |pc[1:0];
    assign mis_d       = (state_q == IDLE && ce && !br) ? misaligned : mis_q;
    // Only a HOLD entered straight from IDLE can carry the misalign flag.
    assign id_mis_d    = br ? 1'b0 : id_stall ? id_mis_q : done && state_q == HOLD && mis_q;
    assign id_misalign = id_mis_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q    <= 1'b0;
            id_mis_q <= 1'b0;
        end else begin
            mis_q    <= mis_d;
            id_mis_q <= id_mis_d;
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (ce && !br) begin
                addr_d  = pc;
                buf_d   = NOP_INST;
                state_d = misaligned ? HOLD : REQ;
            end
            REQ: begin
                if (imem_gnt) state_d = br ? DROP : WAIT;
                else if (br) state_d = IDLE;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    buf_d   = imem_rdata;
                    state_d = (!br && id_stall) ? HOLD : IDLE;
                end else if (br) state_d = DROP;
            end
            DROP: if (imem_rvalid) state_d = IDLE;
            HOLD: if (br || !id_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A fetch retires into IF/ID only when neither flushed nor stalled.
        done       = !br && !id_stall && ((state_q == WAIT && imem_rvalid) || state_q == HOLD);
        done_inst  = (state_q == HOLD) ? buf_q : imem_rdata;
        id_valid_d = br ? 1'b0 : id_stall ? id_valid_q : done;
        id_inst_d  = br ? NOP_INST : id_stall ? id_inst_q : done ? done_inst : NOP_INST;
        id_pc_d    = done ? addr_q : id_pc_q;
        req_d      = state_d == REQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            buf_q      <= NOP_INST;
            req_q      <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP_INST;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            req_q      <= req_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_stall  = state_q != IDLE;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a transaction-level model.
module tb_inst_fetch;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef INST_FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst, ce, br, imem_gnt, imem_rvalid, id_stall;
    logic [31:0] pc, imem_rdata;
    logic        imem_req, if_stall, id_valid, id_misalign;
    logic [31:0] imem_addr, id_pc, id_inst;
    int          n_cmp = 0, n_err = 0;

    // Model: a pending request, one in-flight transaction, and the IF/ID view.
    logic        m_req, m_act, m_ret, m_fl, m_mis;
    logic [31:0] m_addr, m_data;
    logic        e_valid, e_mis;
    logic [31:0] e_pc, e_inst, keep;

    inst_fetch #(.NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .ce(ce), .br(br),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_stall(id_stall),
        .if_stall(if_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
`ifdef INST_FETCH_MISALIGN_CHECK_EN
        , .id_misalign(id_misalign)
`endif
    );
`ifndef INST_FETCH_MISALIGN_CHECK_EN
    assign id_misalign = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic dlv;
        dlv = 1'b0;
        if (rst) begin
            {m_req, m_act, m_ret, m_fl, m_mis} = '0;
            m_addr = 32'h0; m_data = NOP;
            e_valid = 1'b0; e_mis = 1'b0; e_pc = 32'h0; e_inst = NOP;
        end else begin
            if (!m_req && !m_act) begin
                if (ce && !br) begin
                    m_addr = pc;
                    if (MIS_EN && pc[1:0] != 2'b00) begin
                        m_act = 1'b1; m_ret = 1'b1; m_fl = 1'b0; m_data = NOP; m_mis = 1'b1;
                    end else m_req = 1'b1;
                end
            end else if (m_req) begin
                if (imem_gnt) begin
                    m_req = 1'b0; m_act = 1'b1; m_ret = 1'b0; m_fl = br; m_mis = 1'b0;
                end else if (br) m_req = 1'b0;
            end else begin
                if (br) m_fl = 1'b1;
                if (imem_rvalid && !m_ret) begin m_ret = 1'b1; m_data = imem_rdata; end
                if (m_ret) begin
                    if (m_fl) m_act = 1'b0;
                    else if (!id_stall) begin dlv = 1'b1; m_act = 1'b0; end
                end
            end
            if (br) begin e_valid = 1'b0; e_inst = NOP; e_mis = 1'b0; end
            else if (!id_stall) begin
                e_valid = dlv;
                e_inst  = dlv ? m_data : NOP;
                e_mis   = dlv && m_mis;
                if (dlv) e_pc = m_addr;
            end
        end
        @(posedge clk); #1;
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_addr);
        chk("if_stall", if_stall, m_req || m_act);
        chk("id_valid", id_valid, e_valid);
        chk("id_pc", id_pc, e_pc);
        chk("id_inst", id_inst, e_inst);
        if (MIS_EN) chk("id_misalign", id_misalign, e_mis);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; br = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        id_stall = 1'b0; pc = 32'h0; imem_rdata = 32'h0;
        step(); step();
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_valid", id_valid, 1'b0);
        rst = 1'b0;

        // basic fetch latency
        ce = 1'b1; pc = 32'h0; step();
        chk("t1_stall_a", if_stall, 1'b1);
        ce = 1'b0; imem_gnt = 1'b1; step();
        chk("t1_stall_b", if_stall, 1'b1);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004; step();
        imem_rvalid = 1'b0;
        chk("t1_valid", id_valid, 1'b1);
        chk("t1_pc", id_pc, 32'h0);
        chk("t1_inst", id_inst, 32'h8C01_0004);

        // grant withheld for 4 cycles
        ce = 1'b1; pc = 32'h10; step();
        ce = 1'b0; pc = 32'h44;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_req", imem_req, 1'b1);
            chk("t2_addr", imem_addr, 32'h10);
        end
        imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; step();
        imem_rvalid = 1'b0;
        chk("t2_inst", id_inst, 32'h1234_5678);
        chk("t2_pc", id_pc, 32'h10);

        // response arrives under decode back-pressure
        id_stall = 1'b1; ce = 1'b1; pc = 32'h30; step();
        ce = 1'b0; imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2042_0001; step();
        imem_rvalid = 1'b0; step(); step();
        chk("t3_hold", id_inst, 32'h1234_5678);
        chk("t3_stall", if_stall, 1'b1);
        id_stall = 1'b0; step();
        chk("t3_inst", id_inst, 32'h2042_0001);
        chk("t3_pc", id_pc, 32'h30);

        // branch while waiting for data
        ce = 1'b1; pc = 32'h20; step();
        ce = 1'b0; imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; br = 1'b1; step();
        br = 1'b0; step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step();
        imem_rvalid = 1'b0;
        chk("t4_valid", id_valid, 1'b0);
        chk("t4_inst", id_inst, NOP);
        ce = 1'b1; pc = 32'h100; step();
        chk("t4_addr", imem_addr, 32'h100);
        ce = 1'b0; imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001; step();
        imem_rvalid = 1'b0;
        chk("t4_pc", id_pc, 32'h100);

        // branch overrides stall
        br = 1'b1; id_stall = 1'b1; step();
        br = 1'b0; id_stall = 1'b0;
        chk("t5_valid", id_valid, 1'b0);
        chk("t5_inst", id_inst, 32'h0);

        // reset while waiting, late response ignored
        ce = 1'b1; pc = 32'h40; step();
        ce = 1'b0; imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; rst = 1'b1; step();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; step();
        imem_rvalid = 1'b0; step();
        chk("t6_valid", id_valid, 1'b0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_inst", id_inst, NOP);
        chk("t6_stall", if_stall, 1'b0);

        if (MIS_EN) begin
            ce = 1'b1; pc = 32'h6; step();
            chk("t7_req_a", imem_req, 1'b0);
            ce = 1'b0; step();
            chk("t7_req_b", imem_req, 1'b0);
            chk("t7_valid", id_valid, 1'b1);
            chk("t7_mis", id_misalign, 1'b1);
            chk("t7_inst", id_inst, NOP);
            step();
            chk("t7_clear", id_misalign, 1'b0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            ce = $urandom_range(0, 3) != 0;
            pc = $urandom & ((MIS_EN && $urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            br = $urandom_range(0, 15) == 0;
            id_stall = $urandom_range(0, 3) == 0;
            imem_gnt = imem_req && $urandom_range(0, 2) != 0;
            imem_rvalid = m_act && !m_ret && $urandom_range(0, 2) == 0;
            imem_rdata = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Samples the current PC and its chip-enable, issues one instruction-memory read at a time over a req/gnt + rvalid handshake, and loads the returned word into the IF/ID pipeline register for decode.
- Handles decode back-pressure (id_stall) and branch flush (br); raises if_stall so the pipeline controller can freeze the PC while a fetch is outstanding.

Parameters:
- NOP_INST, 32'h0000_0000, instruction word driven on id_inst when the IF/ID register is empty or flushed.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc  in  32  fetch address from PC register
- ce  in  1  PC valid; fetch permitted when 1
- br  in  1  branch taken this cycle; flushes fetch and IF/ID
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  read address, stable while imem_req=1
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- id_stall  in  1  decode cannot accept a new instruction
- if_stall  out  1  fetch busy; PC must hold
- id_valid  out  1  IF/ID register holds a valid instruction
- id_pc  out  32  PC of id_inst
- id_inst  out  32  fetched instruction

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, imem_req=0, imem_addr=0, id_valid=0, id_pc=0, id_inst=NOP_INST, buffer empty. Reset mid-transaction abandons it; a late imem_rvalid after reset is ignored (state is IDLE).
- At most one outstanding read; imem_req and imem_addr are registered outputs.
- if_stall=1 in REQ, WAIT, DROP and HOLD; 0 in IDLE.
- States:
  - IDLE: if ce=1 and br=0, latch addr_q<=pc and go to REQ. Otherwise stay in IDLE.
  - REQ: imem_req=1, imem_addr=addr_q.
    - gnt=1 and br=0: go to WAIT.
    - gnt=1 and br=1: go to DROP.
    - gnt=0 and br=1: withdraw the request, go to IDLE.
    - gnt=0 and br=0: hold the request unchanged.
  - WAIT:
    - rvalid=1 and br=1: discard the data, go to IDLE.
    - rvalid=1, br=0, id_stall=0: load IF/ID (id_valid=1, id_pc=addr_q, id_inst=rdata), go to IDLE.
    - rvalid=1, br=0, id_stall=1: capture rdata into buf, go to HOLD.
    - rvalid=0 and br=1: go to DROP.
  - DROP: wait for rvalid; on rvalid, discard the data and go to IDLE. br in DROP has no further effect.
  - HOLD:
    - br=1: discard buf, go to IDLE.
    - id_stall=0: load IF/ID from buf/addr_q, go to IDLE.
- IF/ID register update, in priority order:
  1. br=1: id_valid<=0, id_inst<=NOP_INST, id_pc unchanged.
  2. id_stall=1: hold.
  3. A fetch completes this cycle: load it.
  4. Otherwise: id_valid<=0, id_inst<=NOP_INST (bubble).
- Timing: with gnt in the REQ cycle and rvalid one cycle later, PC sampled in cycle N gives id_valid=1 at edge N+3. Back-to-back throughput is 1 instruction per 3 cycles.
- br overrides id_stall.
- A response is never consumed twice.
- imem_addr is not re-sampled from pc while in REQ.

Optional Feature:
- Macro: INST_FETCH_MISALIGN_CHECK_EN.
- Enabled:
  - Extra output id_misalign (1 bit), reset 0.
  - In IDLE, with ce=1, br=0 and pc[1:0]!=0, no memory request is issued; the block goes directly to HOLD with buf=NOP_INST and a misalign flag set.
  - On transfer to IF/ID: id_valid=1, id_inst=NOP_INST, id_misalign=1.
  - id_misalign clears with any flush, bubble or normal load.
- Disabled: port absent; pc[1:0] ignored; address passed unchanged.

Test Plan:
- Reset, then ce=1, pc=0x00000000, gnt=1 at first req, rvalid=1 next cycle with rdata=0x8C010004, id_stall=0 -> id_valid=1, id_pc=0x0, id_inst=0x8C010004 exactly 3 cycles after the pc sample; if_stall=1 for the 2 intervening cycles.
- gnt held low 4 cycles with pc=0x10 -> imem_req=1, imem_addr=0x10 stable all 4 cycles; completes normally after gnt.
- rvalid with rdata=0x20420001 while id_stall=1 for 3 cycles -> IF/ID holds its previous contents, if_stall=1; after id_stall falls, id_inst=0x20420001 on the next edge.
- br=1 in WAIT (pc=0x20), rvalid arrives 2 cycles later with rdata=0xDEADBEEF -> id_valid=0, 0xDEADBEEF never appears on id_inst; next fetch uses the new pc (e.g. 0x100).
- br=1 and id_stall=1 in the same cycle with id_valid=1 -> id_valid=0, id_inst=0x00000000 on the next edge.
- rst asserted in WAIT, rvalid arrives 1 cycle after release -> outputs stay at reset values; no IF/ID load. With INST_FETCH_MISALIGN_CHECK_EN, pc=0x6 -> imem_req never asserted, id_valid=1, id_misalign=1, id_inst=NOP_INST.
